// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: samples the single-cycle cpu's retire signals each
// clock, classifies them into 71-bit trace records and queues the records
// in a FIFO for an external drain port. Also keeps cycle/instruction
// counters and sticky halt/timeout/overflow status.
module retire_trace_buffer #(
  parameter int DEPTH       = 16,      // FIFO entries, power of two, >= 2
  parameter int CYCLE_LIMIT = 100000   // capture cycles before forced stop
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc,
  input  logic        reg_write,
  input  logic [3:0]  write_reg,
  input  logic [15:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  input  logic        hlt,
  output logic [70:0] rec_data,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [31:0] cycle_count,
  output logic [31:0] inst_count,
  output logic        overflow,
  output logic        timeout,
  output logic        done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Capture state machine encoding.
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Record kinds.
  localparam logic [2:0] K_NOP   = 3'd0;
  localparam logic [2:0] K_REG   = 3'd1;
  localparam logic [2:0] K_LOAD  = 3'd2;
  localparam logic [2:0] K_STORE = 3'd3;
  localparam logic [2:0] K_HALT  = 3'd4;

  logic [1:0]    r_state;
  logic [31:0]   r_cycle_count;
  logic [31:0]   r_inst_count;
  logic          r_overflow;
  logic          r_timeout;
  logic [70:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic [2:0]    w_kind;
  logic [3:0]    w_reg;
  logic [15:0]   w_value;
  logic [15:0]   w_addr;
  logic [70:0]   w_record;
  logic          w_capture;
  logic [31:0]   w_cycle_next;
  logic          w_hit_limit;
  logic          w_halt;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  // Classify this cycle's retire signals; earlier branches take priority.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    w_kind  = K_NOP;
    w_reg   = 4'd0;
    w_value = 16'd0;
    w_addr  = 16'd0;
    if (reg_write && mem_read) begin
      w_kind  = K_LOAD;
      w_reg   = write_reg;
      w_value = write_data;
      w_addr  = mem_addr;
    end else if (reg_write) begin
      w_kind  = K_REG;
      w_reg   = write_reg;
      w_value = write_data;
    end else if (hlt) begin
      w_kind  = K_HALT;
    end else if (mem_write) begin
      w_kind  = K_STORE;
      w_value = mem_wdata;
      w_addr  = mem_addr;
    end
  end

  // The record's instruction number is the pre-increment count, so the
  // first record after reset carries inum 0.
  assign w_record     = {w_kind, w_reg, r_inst_count[15:0], pc, w_value, w_addr};
  assign w_capture    = (r_state == S_RUN);
  assign w_cycle_next = r_cycle_count + 32'd1;
  assign w_hit_limit  = (w_cycle_next == 32'(CYCLE_LIMIT));
  // A halt shadowed by a same-cycle register write is not a halt record
  // and therefore does not stop capture.
  assign w_halt       = (w_kind == K_HALT);

  // FIFO handshake. A full FIFO still accepts a push when the head leaves
  // on the same edge; otherwise the new record is dropped.
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pop     = !w_empty && rec_ready;
  assign w_push    = w_capture && (!w_full || w_pop);
  assign w_drop    = w_capture && w_full && !w_pop;

  assign rec_valid   = !w_empty;
  // Gate the head so the port reads zero while nothing is buffered,
  // including straight out of reset.
  assign rec_data    = w_empty ? '0 : r_mem[r_rd_ptr];
  assign cycle_count = r_cycle_count;
  assign inst_count  = r_inst_count;
  assign overflow    = r_overflow;
  assign timeout     = r_timeout;
  assign done        = (r_state == S_DONE);

  // Capture state: RUN until halt or cycle limit, DRAIN until empty, then DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or block order.
    if (!rst_n) begin
      r_state <= S_RUN;
    end else begin
      case (r_state)
        S_RUN:   if (w_halt || w_hit_limit) r_state <= S_DRAIN;
        S_DRAIN: if (w_empty) r_state <= S_DONE;
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_RUN;
      endcase
    end
  end

  // Cycle and instruction counters advance only while capturing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_count <= 32'd0;
      r_inst_count  <= 32'd0;
    end else if (w_capture) begin
      r_cycle_count <= w_cycle_next;
      r_inst_count  <= r_inst_count + 32'd1;
    end
  end

  // Sticky status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_drop)                   r_overflow <= 1'b1;
      if (w_capture && w_hit_limit) r_timeout  <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; the pointers and
    // count define which entries are live, and rec_data is gated when empty.
    if (w_push) r_mem[r_wr_ptr] <= w_record;
  end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Self-checking bench for retire_trace_buffer: directed scenarios plus
// randomized episodes, all compared every cycle against a queue-based
// reference model of the trace recorder.
module tb_retire_trace_buffer;

  localparam int DEPTH = 16;
  localparam int CL    = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc = '0;
  logic        reg_write = 1'b0;
  logic [3:0]  write_reg = '0;
  logic [15:0] write_data = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [15:0] mem_wdata = '0;
  logic        hlt = 1'b0;
  logic [70:0] rec_data;
  logic        rec_valid;
  logic        rec_ready = 1'b0;
  logic [31:0] cycle_count;
  logic [31:0] inst_count;
  logic        overflow;
  logic        timeout;
  logic        done;

  retire_trace_buffer #(.DEPTH(DEPTH), .CYCLE_LIMIT(CL)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .reg_write(reg_write),
    .write_reg(write_reg), .write_data(write_data), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .hlt(hlt), .rec_data(rec_data), .rec_valid(rec_valid),
    .rec_ready(rec_ready), .cycle_count(cycle_count),
    .inst_count(inst_count), .overflow(overflow), .timeout(timeout),
    .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [70:0] got,
                       input logic [70:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 capturing, 1 draining, 2 finished
  int          m_phase;
  logic [70:0] m_q[$];
  logic [31:0] m_cyc;
  logic [31:0] m_inst;
  bit          m_ovf;
  bit          m_tmo;

  function automatic void model_reset();
    m_phase = 0;
    m_q.delete();
    m_cyc  = 0;
    m_inst = 0;
    m_ovf  = 0;
    m_tmo  = 0;
  endfunction

  // Apply one clock edge using the inputs currently on the pins.
  function automatic void model_step();
    int          sz  = m_q.size();
    bit          pop = (sz != 0) && rec_ready;
    logic [2:0]  kind;
    logic [3:0]  rg;
    logic [15:0] val;
    logic [15:0] adr;
    if (m_phase == 0) begin
      rg = 0; val = 0; adr = 0;
      if (reg_write && mem_read) begin
        kind = 2; rg = write_reg; val = write_data; adr = mem_addr;
      end else if (reg_write) begin
        kind = 1; rg = write_reg; val = write_data;
      end else if (hlt) begin
        kind = 4;
      end else if (mem_write) begin
        kind = 3; val = mem_wdata; adr = mem_addr;
      end else begin
        kind = 0;
      end
      if (pop) void'(m_q.pop_front());
      if (m_q.size() < DEPTH)
        m_q.push_back({kind, rg, m_inst[15:0], pc, val, adr});
      else
        m_ovf = 1;
      m_inst = m_inst + 1;
      m_cyc  = m_cyc + 1;
      if (m_cyc == CL) begin
        m_tmo   = 1;
        m_phase = 1;
      end
      if (kind == 4) m_phase = 1;
    end else begin
      if (m_phase == 1 && sz == 0) m_phase = 2;
      if (pop) void'(m_q.pop_front());
    end
  endfunction

  task automatic compare();
    logic [70:0] head;
    head = (m_q.size() != 0) ? m_q[0] : 71'd0;
    check("rec_valid", rec_valid, m_q.size() != 0);
    check("rec_data", rec_data, head);
    check("cycle_count", cycle_count, m_cyc);
    check("inst_count", inst_count, m_inst);
    check("overflow", overflow, m_ovf);
    check("timeout", timeout, m_tmo);
    check("done", done, m_phase == 2);
  endtask

  // Inputs are set by the caller at a falling edge; one tick applies them.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle_inputs();
    pc = 0; reg_write = 0; write_reg = 0; write_data = 0; mem_read = 0;
    mem_write = 0; mem_addr = 0; mem_wdata = 0; hlt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    rec_ready = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    compare();
    rst_n = 1'b1;
  endtask

  task automatic drain_to_done(input string tag);
    rec_ready = 1'b1;
    idle_inputs();
    for (int i = 0; i < 200 && m_phase != 2; i++) tick();
    tick();
    check(tag, done, 1'b1);
  endtask

  int ready_pct;

  initial begin
    // ---- reset values ----
    do_reset();
    check("rst_valid", rec_valid, 1'b0);
    check("rst_data", rec_data, 71'd0);
    check("rst_cycles", cycle_count, 32'd0);

    // ---- three register writes ----
    rec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      reg_write = 1; write_reg = 5; write_data = 16'h00AA; pc = 16'(2 * i);
      tick();
      if (i == 0) check("first_rec", rec_data,
                        {3'd1, 4'd5, 16'd0, 16'd0, 16'h00AA, 16'd0});
    end
    check("inst3", inst_count, 32'd3);

    // ---- load then store ----
    idle_inputs();
    reg_write = 1; mem_read = 1; mem_addr = 16'h0040; write_data = 16'h1234;
    write_reg = 3; pc = 16'h0006;
    tick();
    idle_inputs();
    mem_write = 1; mem_addr = 16'h0042; mem_wdata = 16'hBEEF; pc = 16'h0008;
    tick();
    check("store_head", rec_data,
          {3'd3, 4'd0, 16'd4, 16'h0008, 16'hBEEF, 16'h0042});
    // halt shadowed by a register write keeps capture running
    idle_inputs();
    reg_write = 1; hlt = 1; write_reg = 7; write_data = 16'h0055;
    tick();
    check("hlt_regwrite_runs", done | timeout, 1'b0);
    drain_to_done("halt_after_load_done");

    // ---- four NOPs then halt ----
    do_reset();
    rec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc = 16'(2 * i + 8);
      tick();
    end
    pc = 16'h0010; hlt = 1;
    tick();
    check("halt_rec", rec_data,
          {3'd4, 4'd0, 16'd4, 16'h0010, 16'd0, 16'd0});
    check("halt_cycles", cycle_count, 32'd5);
    idle_inputs();
    repeat (3) tick();
    check("halt_cycles_frozen", cycle_count, 32'd5);
    check("halt_done", done, 1'b1);

    // ---- overflow with consumer stalled ----
    do_reset();
    rec_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pc = 16'(i); write_data = 16'(i); reg_write = 1; write_reg = 4'(i);
      tick();
    end
    check("ovf_flag", overflow, 1'b1);
    check("ovf_inst", inst_count, 32'd20);
    check("ovf_head_inum", rec_data[63:48], 71'd0);
    drain_to_done("ovf_done");

    // ---- full FIFO with consumer active: no drop ----
    do_reset();
    rec_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pc = 16'(i); tick();
    end
    rec_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pc = 16'(100 + i); tick();
    end
    check("full_pop_no_ovf", overflow, 1'b0);
    check("full_pop_count", inst_count, 32'(DEPTH + 10));

    // ---- timeout without halt ----
    do_reset();
    rec_ready = 1'b1;
    for (int i = 0; i < CL; i++) begin
      pc = 16'(i); mem_write = 1; mem_wdata = 16'(i * 3); mem_addr = 16'(i);
      tick();
    end
    check("tmo_flag", timeout, 1'b1);
    check("tmo_inst", inst_count, 32'(CL));
    idle_inputs();
    repeat (3) tick();
    check("tmo_frozen", inst_count, 32'(CL));
    drain_to_done("tmo_done");

    // ---- asynchronous reset mid-run ----
    do_reset();
    rec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      reg_write = 1; write_data = 16'(i); tick();
    end
    check("pre_rst_valid", rec_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", rec_valid, 1'b0);
    check("async_rst_cycles", cycle_count, 32'd0);
    check("async_rst_inst", inst_count, 32'd0);
    model_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;

    // ---- randomized episodes ----
    for (int ep = 0; ep < 20; ep++) begin
      do_reset();
      ready_pct = $urandom_range(20, 100);
      for (int c = 0; c < 200 && m_phase != 2; c++) begin
        pc         = 16'($urandom);
        reg_write  = ($urandom_range(0, 2) == 0);
        write_reg  = 4'($urandom);
        write_data = 16'($urandom);
        mem_read   = $urandom_range(0, 1) == 1;
        mem_write  = $urandom_range(0, 1) == 1;
        mem_addr   = 16'($urandom);
        mem_wdata  = 16'($urandom);
        hlt        = ($urandom_range(0, 24) == 0);
        rec_ready  = (c > 100) || ($urandom_range(0, 99) < ready_pct);
        tick();
      end
      check("rand_done", done, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
